wb_sdram_arbiter: RTL and testbench

Two-master Wishbone B3 classic arbiter in front of the single SDRAM controller slave port in the picorv32 Wishbone SoC, running in the wb_clk domain. Master 0 is the CPU data/instruction bus; master 1 is a secondary bus master (DMA/framebuffer). Masters are served round-robin, and a grant is held for a whole cycle (cyc high). A watchdog terminates a stalled slave with err so neither master hangs.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/wb_arb_watchdog.sv | 31 +++
 rtl/wb_sdram_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_sdram_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared state encoding and watchdog width helper for the SDRAM port arbiter
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT0  = 2'd1,
        ST_GNT1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_t;

    // Counter only has to reach TIMEOUT-1; keep at least one bit so TIMEOUT of 0/1 still elaborates.
    function automatic int wd_width(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// rtl/wb_arb_watchdog.sv - stalled-slave watchdog: counts unanswered strobe cycles, flags expiry
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW    = wd_width(TIMEOUT);
    localparam int LASTI = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] LAST = LASTI[CW-1:0];

    logic [CW-1:0] count;

    // A response in the final cycle wins over expiry, so a just-in-time ack is never turned into err.
    assign expire = (TIMEOUT != 0) && enable && !clear && (count == LAST);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_sdram_arbiter.sv
// rtl/wb_sdram_arbiter.sv - two-master round-robin Wishbone arbiter in front of the SDRAM controller
module wb_sdram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024,
    parameter int PRIO0   = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    output logic [1:0]      gnt_o
);

    arb_state_t state, next_state;
    logic       last, next_last;   // master served most recently (1 = master 1)
    logic       wd_expire;

    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .clear  (s_ack_i || s_err_i || !s_stb_o),
        .enable (s_stb_o),
        .expire (wd_expire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
            last  <= (PRIO0 != 0);
        end else begin
            state <= next_state;
            last  <= next_last;
        end
    end

    always_comb begin
        next_state = state;
        next_last  = last;
        case (state)
            ST_IDLE: begin
                if (m0_cyc_i && (!m1_cyc_i || last)) begin
                    next_state = ST_GNT0;
                    next_last  = 1'b0;
                end else if (m1_cyc_i) begin
                    next_state = ST_GNT1;
                    next_last  = 1'b1;
                end
            end
            ST_GNT0: begin
                if (!m0_cyc_i)      next_state = ST_IDLE;
                else if (wd_expire) next_state = ST_ABORT;
            end
            ST_GNT1: begin
                if (!m1_cyc_i)      next_state = ST_IDLE;
                else if (wd_expire) next_state = ST_ABORT;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Slave-side mux and response routing; everything idles at zero outside a grant.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        gnt_o    = 2'b00;
        case (state)
            ST_GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = s_err_i;
                gnt_o    = 2'b01;
            end
            ST_GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = s_err_i;
                gnt_o    = 2'b10;
            end
            ST_ABORT: begin
                // The aborted owner is the one recorded on grant entry.
                m0_err_o = !last;
                m1_err_o = last;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// tb/tb_wb_sdram_arbiter.sv - self-checking bench for wb_sdram_arbiter
module tb_wb_sdram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clock = 1'b0;
    logic            reset;
    logic [AW-1:0]   m0_adr, m1_adr, s_adr_o;
    logic [DW-1:0]   m0_dat, m1_dat, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [DW/8-1:0] m0_sel, m1_sel, s_sel_o;
    logic            m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
    logic            m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic            s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
    logic [1:0]      gnt_o;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    wb_sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO), .PRIO0(1)) dut (
        .clock(clock), .reset(reset),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_sel_i(m0_sel), .m0_we_i(m0_we),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_sel_i(m1_sel), .m1_we_i(m1_we),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o)
    );

    task automatic idle_inputs();
        m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drive_req(input int m, input logic on);
        if (m == 0) begin m0_cyc = on; m0_stb = on; end
        else        begin m1_cyc = on; m1_stb = on; end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_ack_o : m1_ack_o;
    endfunction

    function automatic logic [DW-1:0] dat_of(input int m);
        return (m == 0) ? m0_dat_o : m1_dat_o;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        s_ack_i = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b want 00", gnt_o); end
        tests++; if ({s_cyc_o, s_stb_o, s_we_o} !== 3'b000) begin fails++; $display("FAIL reset_ctl: got %b want 000", {s_cyc_o, s_stb_o, s_we_o}); end
        tests++; if ({s_adr_o, s_dat_o, s_sel_o} !== '0) begin fails++; $display("FAIL reset_bus: got %h/%h/%h want 0", s_adr_o, s_dat_o, s_sel_o); end
        tests++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin fails++; $display("FAIL reset_resp: got %b want 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
        s_ack_i = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_adr = 32'h100; m0_sel = 4'hF; drive_req(0, 1'b1);
        #1;
        tests++; if (s_cyc_o !== 1'b0) begin fails++; $display("FAIL read_latency: s_cyc_o got %b want 0", s_cyc_o); end
        @(negedge clock); #1;
        tests++; if ({gnt_o, s_cyc_o, s_stb_o} !== 4'b0111) begin fails++; $display("FAIL read_grant: got %b want 0111", {gnt_o, s_cyc_o, s_stb_o}); end
        tests++; if (s_adr_o !== 32'h100) begin fails++; $display("FAIL read_adr: got %h want 100", s_adr_o); end
        @(negedge clock); #1;
        tests++; if (m0_ack_o !== 1'b0) begin fails++; $display("FAIL read_noack: got %b want 0", m0_ack_o); end
        @(negedge clock);
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        #1;
        tests++; if ({m0_ack_o, m0_dat_o} !== {1'b1, 32'hDEADBEEF}) begin fails++; $display("FAIL read_ack: got %b/%h want 1/deadbeef", m0_ack_o, m0_dat_o); end
        tests++; if ({m1_ack_o, m1_dat_o} !== '0) begin fails++; $display("FAIL read_other: got %b/%h want 0/0", m1_ack_o, m1_dat_o); end
        @(negedge clock);
        s_ack_i = 1'b0; drive_req(0, 1'b0);
        #1;
        tests++; if (s_cyc_o !== 1'b0) begin fails++; $display("FAIL read_cycdrop: s_cyc_o got %b want 0", s_cyc_o); end
        @(negedge clock); #1;
        tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL read_release: got %b want 00", gnt_o); end
    endtask

    task automatic test_contention();
        do_reset();
        m0_adr = 32'h200; m1_adr = 32'h300;
        drive_req(0, 1'b1); drive_req(1, 1'b1);
        @(negedge clock); #1;
        tests++; if ({gnt_o, s_adr_o} !== {2'b01, 32'h200}) begin fails++; $display("FAIL cont_first: got %b/%h want 01/200", gnt_o, s_adr_o); end
        s_ack_i = 1'b1; drive_req(0, 1'b0);
        #1;
        tests++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin fails++; $display("FAIL cont_dropack: got %b want 10", {m0_ack_o, m1_ack_o}); end
        @(negedge clock);
        s_ack_i = 1'b0;
        #1;
        tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL cont_dead: got %b want 00", gnt_o); end
        @(negedge clock); #1;
        tests++; if ({gnt_o, s_adr_o} !== {2'b10, 32'h300}) begin fails++; $display("FAIL cont_second: got %b/%h want 10/300", gnt_o, s_adr_o); end
        s_ack_i = 1'b1;
        #1;
        tests++; if ({m0_ack_o, m1_ack_o} !== 2'b01) begin fails++; $display("FAIL cont_ack1: got %b want 01", {m0_ack_o, m1_ack_o}); end
        @(negedge clock);
        s_ack_i = 1'b0; drive_req(1, 1'b0);
        @(negedge clock);
        drive_req(0, 1'b1); drive_req(1, 1'b1);
        @(negedge clock); #1;
        tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL cont_alternate: got %b want 01", gnt_o); end
        drive_req(0, 1'b0); drive_req(1, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_burst();
        logic [DW-1:0] rd;
        m1_adr = 32'h1000; drive_req(1, 1'b1);
        @(negedge clock);
        drive_req(0, 1'b1);
        for (int b = 0; b < 8; b++) begin
            m1_adr = 32'h1000 + 32'(4 * b);
            rd = $urandom;
            s_ack_i = 1'b1; s_dat_i = rd;
            #1;
            tests++; if ({gnt_o, m1_ack_o, m0_ack_o} !== 4'b1010) begin fails++; $display("FAIL burst_beat%0d: got %b want 1010", b, {gnt_o, m1_ack_o, m0_ack_o}); end
            tests++; if ({s_adr_o, m1_dat_o} !== {m1_adr, rd}) begin fails++; $display("FAIL burst_data%0d: got %h/%h want %h/%h", b, s_adr_o, m1_dat_o, m1_adr, rd); end
            @(negedge clock);
        end
        s_ack_i = 1'b0; drive_req(1, 1'b0);
        @(negedge clock); #1;
        tests++; if (gnt_o !== 2'b00) begin fails++; $display("FAIL burst_dead: got %b want 00", gnt_o); end
        @(negedge clock); #1;
        tests++; if (gnt_o !== 2'b01) begin fails++; $display("FAIL burst_handover: got %b want 01", gnt_o); end
        drive_req(0, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_watchdog();
        int errs = 0;
        int err_at = -1;
        int m1_errs = 0;
        m0_adr = 32'h400; drive_req(0, 1'b1);
        @(negedge clock);
        for (int i = 0; i <= 20; i++) begin
            s_ack_i = (i == 16 || i == 17);
            #1;
            if (m0_err_o === 1'b1) begin errs++; if (err_at < 0) err_at = i; end
            if (m1_err_o === 1'b1) m1_errs++;
            if (i >= 15 && i <= 17) begin
                tests++; if (s_cyc_o !== (i < 16)) begin fails++; $display("FAIL wd_cyc%0d: got %b want %b", i, s_cyc_o, (i < 16)); end
            end
            if (i == 16 || i == 17) begin
                tests++; if ({m0_ack_o, m1_ack_o} !== 2'b00) begin fails++; $display("FAIL wd_lateack%0d: got %b want 00", i, {m0_ack_o, m1_ack_o}); end
            end
            @(negedge clock);
        end
        tests++; if ({errs, err_at, m1_errs} !== {32'd1, 32'd16, 32'd0}) begin fails++; $display("FAIL wd_pulse: got count %0d at %0d (m1 %0d) want 1 at 16 (m1 0)", errs, err_at, m1_errs); end
        s_ack_i = 1'b0; drive_req(0, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_mid();
        m1_adr = 32'h500; drive_req(1, 1'b1);
        @(negedge clock); #1;
        tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL rmid_grant: got %b want 10", gnt_o); end
        reset = 1'b1;
        @(negedge clock); #1;
        tests++; if ({gnt_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o} !== 6'b0) begin fails++; $display("FAIL rmid_cleared: got %b want 000000", {gnt_o, s_cyc_o, s_stb_o, m1_ack_o, m1_err_o}); end
        reset = 1'b0;
        @(negedge clock); #1;
        tests++; if (gnt_o !== 2'b10) begin fails++; $display("FAIL rmid_regrant: got %b want 10", gnt_o); end
        drive_req(1, 1'b0);
        repeat (2) @(negedge clock);
    endtask

    task automatic test_write();
        m0_adr = 32'h600; m0_dat = 32'h12345678; m0_sel = 4'b0011; m0_we = 1'b1;
        drive_req(0, 1'b1);
        @(negedge clock); #1;
        tests++; if ({gnt_o, s_we_o, s_sel_o} !== {2'b01, 1'b1, 4'b0011}) begin fails++; $display("FAIL write_ctl: got %b/%b/%b want 01/1/0011", gnt_o, s_we_o, s_sel_o); end
        tests++; if ({s_adr_o, s_dat_o} !== {32'h600, 32'h12345678}) begin fails++; $display("FAIL write_data: got %h/%h want 600/12345678", s_adr_o, s_dat_o); end
        s_ack_i = 1'b1;
        #1;
        tests++; if (m0_ack_o !== 1'b1) begin fails++; $display("FAIL write_ack: got %b want 1", m0_ack_o); end
        @(negedge clock);
        s_ack_i = 1'b0; drive_req(0, 1'b0); m0_we = 1'b0;
        repeat (2) @(negedge clock);
    endtask

    // Reference: transaction-level round-robin order, each master completing one acked transfer.
    task automatic test_random();
        logic [AW-1:0]   adr [2];
        logic [DW-1:0]   wdat [2];
        logic [DW/8-1:0] sel [2];
        logic            we [2];
        logic [DW-1:0]   rd;
        bit              m1_served_last;
        int              order[$];
        int              kind, first, lat;
        bit              found, same;
        do_reset();
        m1_served_last = 1'b1;
        for (int it = 0; it < 40; it++) begin
            kind = $urandom_range(0, 2);
            order.delete();
            if (kind == 2) begin
                first = m1_served_last ? 0 : 1;
                order.push_back(first);
                order.push_back(1 - first);
                m1_served_last = (first == 0);
            end else begin
                order.push_back(kind);
                m1_served_last = (kind == 1);
            end
            for (int m = 0; m < 2; m++) begin
                adr[m] = $urandom; wdat[m] = $urandom; sel[m] = 4'($urandom); we[m] = 1'($urandom);
            end
            m0_adr = adr[0]; m0_dat = wdat[0]; m0_sel = sel[0]; m0_we = we[0];
            m1_adr = adr[1]; m1_dat = wdat[1]; m1_sel = sel[1]; m1_we = we[1];
            foreach (order[j]) drive_req(order[j], 1'b1);
            foreach (order[j]) begin
                int m = order[j];
                found = 1'b0;
                for (int k = 0; k < 4 && !found; k++) begin
                    @(negedge clock); #1;
                    found = (gnt_o != 2'b00);
                end
                tests++;
                if (!found) begin
                    fails++; $display("FAIL rand%0d_timeout: no grant for m%0d", it, m);
                end else if (gnt_o !== ((m == 0) ? 2'b01 : 2'b10)) begin
                    fails++; $display("FAIL rand%0d_order: got gnt %b want m%0d", it, gnt_o, m);
                end
                tests++;
                if ({s_adr_o, s_we_o, s_sel_o, s_dat_o} !== {adr[m], we[m], sel[m], wdat[m]}) begin
                    fails++; $display("FAIL rand%0d_mux: got %h/%b/%b/%h want %h/%b/%b/%h", it, s_adr_o, s_we_o, s_sel_o, s_dat_o, adr[m], we[m], sel[m], wdat[m]);
                end
                lat = $urandom_range(0, 3);
                repeat (lat) @(negedge clock);
                rd = $urandom;
                same = 1'($urandom);
                s_ack_i = 1'b1; s_dat_i = rd;
                if (same) drive_req(m, 1'b0);
                #1;
                tests++;
                if ({ack_of(m), dat_of(m), ack_of(1 - m), dat_of(1 - m)} !== {1'b1, rd, 1'b0, 32'h0}) begin
                    fails++; $display("FAIL rand%0d_resp: m%0d got %b/%h other %b/%h want 1/%h other 0/0", it, m, ack_of(m), dat_of(m), ack_of(1 - m), dat_of(1 - m), rd);
                end
                @(negedge clock);
                s_ack_i = 1'b0;
                drive_req(m, 1'b0);
            end
            @(negedge clock);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_burst();
        test_watchdog();
        test_reset_mid();
        test_write();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
